// File: rtl/maze_solver_ctrl.sv
// -----------------------------------------------------------------------------
// maze_solver_ctrl
//
// Depth-first maze solver. It drives a 16x16 one-bit maze memory, walks from
// (START_X, START_Y) toward (GOAL_X, GOAL_Y), and marks every cell it enters by
// writing 1. The current path is kept as a stack of 2-bit moves. On a dead end
// the solver pops moves to backtrack.
//
// Directions: 0 = right (x+1), 1 = down (y+1), 2 = left (x-1), 3 = up (y-1).
// Memory cell value: 0 = open, 1 = wall or already visited.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       one-cycle pulse; begins a solve when idle
//   mem_rd      read strobe (memory read is combinational)
//   mem_wr      write strobe
//   mem_x/y     memory column / row address
//   mem_din     write data (1 whenever mem_wr is high)
//   mem_dout    read data from memory
//   busy        solve in progress
//   done        goal reached; held until the next start
//   fail        no path or stack overflow; held until the next start
//   path_len    current stack depth (moves on the current path)
//
// Optional build macro PATH_READOUT_EN adds a streaming readout of the solved
// path after the goal is reached:
//   path_valid  stack entry available
//   path_dir    stack entry (held stable until accepted)
//   path_ready  consumer accepts the entry
// -----------------------------------------------------------------------------
module maze_solver_ctrl #(
   parameter int unsigned START_X     = 0,
   parameter int unsigned START_Y     = 0,
   parameter int unsigned GOAL_X      = 15,
   parameter int unsigned GOAL_Y      = 15,
   parameter int unsigned STACK_DEPTH = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [3:0] mem_x,
   output logic [3:0] mem_y,
   output logic       mem_din,
   input  logic       mem_dout,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [8:0] path_len
`ifdef PATH_READOUT_EN
   ,
   output logic       path_valid,
   output logic [1:0] path_dir,
   input  logic       path_ready
`endif
);

   localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [3:0]      START_X_C = 4'(START_X);
   localparam logic [3:0]      START_Y_C = 4'(START_Y);
   localparam logic [3:0]      GOAL_X_C  = 4'(GOAL_X);
   localparam logic [3:0]      GOAL_Y_C  = 4'(GOAL_Y);
   localparam logic [SP_W-1:0] SP_FULL   = SP_W'(STACK_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_PROBE,
      S_BACK,
      S_FINISH,
      S_FAIL
`ifdef PATH_READOUT_EN
      ,
      S_READOUT
`endif
   } state_e;

   // True when moving one step in direction d stays inside the 16x16 grid.
   function automatic logic in_bounds(input logic [3:0] x, input logic [3:0] y,
                                      input logic [1:0] d);
      case (d)
         2'd0:    in_bounds = (x != 4'd15);
         2'd1:    in_bounds = (y != 4'd15);
         2'd2:    in_bounds = (x != 4'd0);
         default: in_bounds = (y != 4'd0);
      endcase
   endfunction

   // Coordinates {x, y} after one step in direction d.
   function automatic logic [7:0] step(input logic [3:0] x, input logic [3:0] y,
                                      input logic [1:0] d);
      logic [3:0] nx;
      logic [3:0] ny;
      nx = x;
      ny = y;
      case (d)
         2'd0:    nx = x + 4'd1;
         2'd1:    ny = y + 4'd1;
         2'd2:    nx = x - 4'd1;
         default: ny = y - 4'd1;
      endcase
      return {nx, ny};
   endfunction

   state_e          state_q, state_d;
   logic [3:0]      pos_x_q, pos_x_d;
   logic [3:0]      pos_y_q, pos_y_d;
   logic [1:0]      dir_q, dir_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            fail_q, fail_d;

   logic [1:0]      stack_q [STACK_DEPTH];
   logic            push_en;
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] pop_idx;
   logic [1:0]      pop_dir;

   logic            nb_ok;
   logic [3:0]      nb_x, nb_y;
   logic [3:0]      bk_x, bk_y;
   logic            sample;

`ifdef PATH_READOUT_EN
   logic [SP_W-1:0] rd_idx_q, rd_idx_d;
`endif

   assign push_idx = sp_q[IDX_W-1:0];
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
   assign pop_dir  = stack_q[pop_idx];

   assign nb_ok        = in_bounds(pos_x_q, pos_y_q, dir_q);
   assign {nb_x, nb_y} = step(pos_x_q, pos_y_q, dir_q);
   // Backtracking undoes a move: the opposite direction is d with bit 1 flipped.
   assign {bk_x, bk_y} = step(pos_x_q, pos_y_q, pop_dir ^ 2'd2);
   // An out-of-bounds neighbour is never read and behaves like a wall.
   assign sample       = nb_ok ? mem_dout : 1'b1;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      dir_d   = dir_q;
      sp_d    = sp_q;
      busy_d  = busy_q;
      done_d  = done_q;
      fail_d  = fail_q;
      push_en = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      mem_x   = 4'd0;
      mem_y   = 4'd0;
      mem_din = 1'b0;
`ifdef PATH_READOUT_EN
      rd_idx_d = rd_idx_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pos_x_d = START_X_C;
               pos_y_d = START_Y_C;
               dir_d   = 2'd0;
               sp_d    = '0;
               done_d  = 1'b0;
               fail_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_MARK;
            end
         end

         S_MARK: begin
            mem_wr  = 1'b1;
            mem_din = 1'b1;
            mem_x   = pos_x_q;
            mem_y   = pos_y_q;
            if (pos_x_q == GOAL_X_C && pos_y_q == GOAL_Y_C) state_d = S_FINISH;
            else                                            state_d = S_PROBE;
         end

         S_PROBE: begin
            if (nb_ok) begin
               mem_rd = 1'b1;
               mem_x  = nb_x;
               mem_y  = nb_y;
            end
            if (!sample) begin
               if (sp_q == SP_FULL) begin
                  state_d = S_FAIL;
               end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + SP_W'(1);
                  pos_x_d = nb_x;
                  pos_y_d = nb_y;
                  dir_d   = 2'd0;
                  state_d = S_MARK;
               end
            end else if (dir_q != 2'd3) begin
               dir_d = dir_q + 2'd1;
            end else begin
               state_d = S_BACK;
            end
         end

         S_BACK: begin
            if (sp_q == '0) begin
               state_d = S_FAIL;
            end else begin
               sp_d    = sp_q - SP_W'(1);
               pos_x_d = bk_x;
               pos_y_d = bk_y;
               // A popped "up" move has no untried direction left at the parent.
               if (pop_dir != 2'd3) begin
                  dir_d   = pop_dir + 2'd1;
                  state_d = S_PROBE;
               end
            end
         end

         S_FINISH: begin
            done_d = 1'b1;
            busy_d = 1'b0;
`ifdef PATH_READOUT_EN
            rd_idx_d = '0;
            state_d  = S_READOUT;
`else
            state_d  = S_IDLE;
`endif
         end

         S_FAIL: begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

`ifdef PATH_READOUT_EN
         S_READOUT: begin
            if (rd_idx_q == sp_q) begin
               state_d = S_IDLE;
            end else if (path_ready) begin
               rd_idx_d = rd_idx_q + SP_W'(1);
               if (rd_idx_q + SP_W'(1) == sp_q) state_d = S_IDLE;
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the clock edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pos_x_q <= 4'd0;
         pos_y_q <= 4'd0;
         dir_q   <= 2'd0;
         sp_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
`ifdef PATH_READOUT_EN
         rd_idx_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         dir_q   <= dir_d;
         sp_q    <= sp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
`ifdef PATH_READOUT_EN
         rd_idx_q <= rd_idx_d;
`endif
      end
   end

   // NOTE: the path stack has no reset; entries above sp are never read, so
   // clearing them would only cost a reset tree on a large array.
   always_ff @(posedge clk) begin
      if (push_en) stack_q[push_idx] <= dir_q;
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign fail     = fail_q;
   assign path_len = 9'(sp_q);

`ifdef PATH_READOUT_EN
   assign path_valid = (state_q == S_READOUT) && (rd_idx_q != sp_q);
   assign path_dir   = stack_q[rd_idx_q[IDX_W-1:0]];
`endif

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_solver_ctrl
//
// Directed bench for maze_solver_ctrl. Two instances share one behavioural
// 16x16 maze memory: dut_a uses the default start/goal, and dut_s has the goal
// equal to the start (0,0). Only one instance is active at a time. The memory
// model also counts writes, reads, repeated writes and read/write overlap.
// -----------------------------------------------------------------------------
module tb_maze_solver_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_a, start_s;

   logic       a_rd, a_wr, a_din, a_dout, a_busy, a_done, a_fail;
   logic [3:0] a_x, a_y;
   logic [8:0] a_len;
   logic       s_rd, s_wr, s_din, s_dout, s_busy, s_done, s_fail;
   logic [3:0] s_x, s_y;
   logic [8:0] s_len;

`ifdef PATH_READOUT_EN
   logic       a_pvalid, a_pready, s_pvalid, s_pready;
   logic [1:0] a_pdir, s_pdir;
   assign s_pready = 1'b1;
`endif

   maze_solver_ctrl dut_a (
      .clk      (clk),
      .rst      (rst),
      .start    (start_a),
      .mem_rd   (a_rd),
      .mem_wr   (a_wr),
      .mem_x    (a_x),
      .mem_y    (a_y),
      .mem_din  (a_din),
      .mem_dout (a_dout),
      .busy     (a_busy),
      .done     (a_done),
      .fail     (a_fail),
      .path_len (a_len)
`ifdef PATH_READOUT_EN
      ,
      .path_valid (a_pvalid),
      .path_dir   (a_pdir),
      .path_ready (a_pready)
`endif
   );

   maze_solver_ctrl #(.GOAL_X(0), .GOAL_Y(0)) dut_s (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s),
      .mem_rd   (s_rd),
      .mem_wr   (s_wr),
      .mem_x    (s_x),
      .mem_y    (s_y),
      .mem_din  (s_din),
      .mem_dout (s_dout),
      .busy     (s_busy),
      .done     (s_done),
      .fail     (s_fail),
      .path_len (s_len)
`ifdef PATH_READOUT_EN
      ,
      .path_valid (s_pvalid),
      .path_dir   (s_pdir),
      .path_ready (s_pready)
`endif
   );

   // ---------------- maze memory model, indexed [y][x] ----------------
   logic maze    [16][16];
   logic pat     [16][16];
   logic wr_seen [16][16];
   logic load;
   int   wr_cnt, rd_cnt, dup_cnt, both_cnt, din_bad;

   assign a_dout = maze[a_y][a_x];
   assign s_dout = maze[s_y][s_x];

   always @(posedge clk) begin
      if (load) begin
         maze     <= pat;
         wr_cnt   <= 0;
         rd_cnt   <= 0;
         dup_cnt  <= 0;
         both_cnt <= 0;
         din_bad  <= 0;
         for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
               wr_seen[y][x] <= 1'b0;
      end else begin
         if (a_wr) begin
            maze[a_y][a_x]    <= 1'b1;
            wr_seen[a_y][a_x] <= 1'b1;
            if (wr_seen[a_y][a_x]) dup_cnt <= dup_cnt + 1;
            if (!a_din) din_bad <= din_bad + 1;
         end
         if (s_wr) begin
            maze[s_y][s_x]    <= 1'b1;
            wr_seen[s_y][s_x] <= 1'b1;
            if (wr_seen[s_y][s_x]) dup_cnt <= dup_cnt + 1;
            if (!s_din) din_bad <= din_bad + 1;
         end
         wr_cnt <= wr_cnt + ((a_wr || s_wr) ? 1 : 0);
         rd_cnt <= rd_cnt + ((a_rd || s_rd) ? 1 : 0);
         if ((a_rd && a_wr) || (s_rd && s_wr)) both_cnt <= both_cnt + 1;
      end
   end

   // ---------------- checking ----------------
   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_pat(input logic v);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            pat[y][x] = v;
   endtask

   task automatic load_maze();
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
   endtask

   task automatic pulse_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic wait_end_a(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (a_done || a_fail) break;
         @(negedge clk);
      end
      check("solve_terminates", 32'(a_done | a_fail), 1);
   endtask

`ifdef PATH_READOUT_EN
   int         n_xfer;
   logic       stalled;
   logic [1:0] held;
`endif

   initial begin
      rst     = 1'b0;
      start_a = 1'b0;
      start_s = 1'b0;
      load    = 1'b0;
`ifdef PATH_READOUT_EN
      a_pready = 1'b0;
`endif
      fill_pat(1'b0);
      load_maze();

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("reset_outputs",
            32'({a_busy, a_done, a_fail, a_rd, a_wr, a_x, a_y, a_len}), 0);
      rst = 1'b1;

      // ---- all-zero maze, default goal ----
      fill_pat(1'b0);
      load_maze();
      pulse_a();
      wait_end_a(500);
      check("open_done",       32'(a_done), 1);
      check("open_fail",       32'(a_fail), 0);
      check("open_busy",       32'(a_busy), 0);
      check("open_path_len",   32'(a_len), 30);
      check("open_writes",     32'(wr_cnt), 31);
      check("open_dup_writes", 32'(dup_cnt), 0);
      check("open_reads",      32'(rd_cnt), 30);
      check("open_rd_wr",      32'(both_cnt), 0);
      check("open_din",        32'(din_bad), 0);
      check("open_corner",     32'(wr_seen[0][15]), 1);
      check("open_goal_mark",  32'(wr_seen[15][15]), 1);
      check("open_offpath",    32'(wr_seen[1][14]), 0);

`ifdef PATH_READOUT_EN
      // ---- path readout with path_ready toggling ----
      n_xfer  = 0;
      stalled = 1'b0;
      held    = 2'd0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (!a_pvalid) break;
         a_pready = cyc[0];
         if (stalled) check("readout_hold", 32'(a_pdir), 32'(held));
         if (a_pready) begin
            check("readout_dir", 32'(a_pdir), (n_xfer < 15) ? 0 : 1);
            n_xfer++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = a_pdir;
         end
         @(negedge clk);
      end
      a_pready = 1'b0;
      check("readout_count", 32'(n_xfer), 30);
      check("readout_idle",  32'(a_pvalid), 0);
`endif

      // ---- goal equals start: done two clocks after the start edge ----
      fill_pat(1'b0);
      load_maze();
      @(negedge clk) start_s = 1'b1;
      @(negedge clk) start_s = 1'b0;
      check("sg_mark_cycle", 32'({s_busy, s_wr, s_done}), 32'(3'b110));
      @(negedge clk);
      check("sg_done_early", 32'(s_done), 0);
      @(negedge clk);
      check("sg_done_2clk",  32'({s_done, s_busy, s_fail}), 32'(3'b100));
      check("sg_path_len",   32'(s_len), 0);
      check("sg_writes",     32'(wr_cnt), 1);
      check("sg_reads",      32'(rd_cnt), 0);
      check("sg_start_mark", 32'(wr_seen[0][0]), 1);
`ifdef PATH_READOUT_EN
      @(negedge clk);
      check("sg_no_readout", 32'(s_pvalid), 0);
`endif

      // ---- goal walled off: full backtrack, then fail ----
      fill_pat(1'b0);
      pat[15][14] = 1'b1;
      pat[14][15] = 1'b1;
      load_maze();
      pulse_a();
      wait_end_a(20000);
      check("wall_fail",      32'(a_fail), 1);
      check("wall_done",      32'(a_done), 0);
      check("wall_path_len",  32'(a_len), 0);
      check("wall_goal_mark", 32'(wr_seen[15][15]), 0);
      check("wall_writes",    32'(wr_cnt), 253);
      check("wall_dup",       32'(dup_cnt), 0);
      check("wall_rd_wr",     32'(both_cnt), 0);

      // ---- corridor: row 0 then column 14, dead end ----
      fill_pat(1'b1);
      for (int x = 0; x < 16; x++) pat[0][x] = 1'b0;
      for (int y = 1; y < 16; y++) pat[y][14] = 1'b0;
      load_maze();
      pulse_a();
      wait_end_a(2000);
      check("corr_fail",      32'(a_fail), 1);
      check("corr_done",      32'(a_done), 0);
      check("corr_path_len",  32'(a_len), 0);
      check("corr_writes",    32'(wr_cnt), 31);
      check("corr_bottom",    32'(wr_seen[15][14]), 1);
      check("corr_wall_cell", 32'(wr_seen[1][15]), 0);
      check("corr_rd_wr",     32'(both_cnt), 0);

      // ---- asynchronous reset mid-solve, then a clean restart ----
      fill_pat(1'b0);
      load_maze();
      pulse_a();
      for (int i = 0; i < 200; i++) begin
         if (wr_cnt >= 10) break;
         @(negedge clk);
      end
      check("mid_busy", 32'(a_busy), 1);
      #2 rst = 1'b0;
      #1;
      check("mid_reset_outputs",
            32'({a_busy, a_done, a_fail, a_rd, a_wr, a_x, a_y, a_len}), 0);
      @(negedge clk) rst = 1'b1;
      fill_pat(1'b0);
      load_maze();
      pulse_a();
      check("restart_mark", 32'({a_wr, a_x, a_y, a_len}), 32'({1'b1, 17'd0}));
      wait_end_a(500);
      check("restart_done",     32'(a_done), 1);
      check("restart_path_len", 32'(a_len), 30);
      check("restart_writes",   32'(wr_cnt), 31);

      if (n_fail != 0) $display("%0d checks did not pass", n_fail);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
